// File: rtl/window_generator.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window over a raster pixel stream, built from line buffers plus a shift window.
// Latency: one cycle from the accept of the window's bottom-right pixel to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled window holds the stream and the window register.
module window_generator #(
    parameter int KERNEL_SIZE = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_WIDTH-1:0]                         in_pixel,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window,
    output logic                                          frame_done
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] FIRST_WCOL = CW'(K - 1);
    localparam logic [RW-1:0] FIRST_WROW = RW'(K - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  accept;
    logic                  win_hit;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] lbuf [K-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win  [K][K];

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // A window is complete only once K rows and K columns of the current row/frame have arrived,
    // which also keeps stale line-buffer data from a previous frame out of every valid window.
    assign win_hit   = (row >= FIRST_WROW) && (col >= FIRST_WCOL);
    assign frame_end = (row == LAST_ROW) && (col == LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && frame_end;
            if (accept) begin
                out_valid <= win_hit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffer k holds row (row-1-k); each accept ages the column down by one buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col] <= in_pixel;
            for (int k = 1; k < K - 1; k++) begin
                lbuf[k][col] <= lbuf[k-1][col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win[r][K-1] <= lbuf[K-2-r][col];
            end
            win[K-1][K-1] <= in_pixel;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign out_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
        end
    end
endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 5, giving the window side length.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the pixel width (signed Q8.8).
REQ-003 The block SHALL have parameter IMG_WIDTH, default 28, giving pixels per image row.
REQ-004 The block SHALL have parameter IMG_HEIGHT, default 28, giving rows per image frame.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_pixel carries a valid raster-order pixel.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts in_pixel this cycle.
REQ-009 The block SHALL have port in_pixel, input, DATA_WIDTH, the pixel value.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_window holds a complete window.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the downstream multiplier/adder datapath consumes out_window.
REQ-012 The block SHALL have port out_window, output, KERNEL_SIZE**2*DATA_WIDTH, the packed window; element r*KERNEL_SIZE+c sits at bits [(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse marking the last window of a frame.

Function
REQ-014 Accept SHALL occur on a cycle with in_valid && in_ready; only an accept SHALL advance any state.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-016 The block SHALL keep KERNEL_SIZE-1 line buffers of IMG_WIDTH entries, holding the previous KERNEL_SIZE-1 rows; on accept at column col, line buffer k SHALL take the old value of line buffer k-1 at col, and line buffer 0 SHALL take in_pixel.
REQ-017 On accept, the window register SHALL shift one column toward c=0; new column c=KERNEL_SIZE-1 SHALL be {rows 0..K-2 from line buffers K-2..0 at col, row K-1 = in_pixel}.
REQ-018 Element r=0,c=0 SHALL be the oldest (top-left) pixel; element r=K-1,c=K-1 SHALL be the pixel just accepted.
REQ-019 Column counter col SHALL count 0..IMG_WIDTH-1 per accept and wrap to 0, incrementing row counter row; row SHALL wrap from IMG_HEIGHT-1 to 0.
REQ-020 out_valid SHALL be set on the cycle after an accept at (row,col) with row >= K-1 and col >= K-1; otherwise an accept SHALL leave out_valid clear.
REQ-021 While out_valid && !out_ready, out_window and out_valid SHALL hold stable.
REQ-022 out_valid SHALL clear after out_valid && out_ready unless the same cycle's accept produces a new window (back-to-back windows, one per cycle).
REQ-023 Latency SHALL be 1 cycle from accept to out_valid.
REQ-024 Each frame SHALL yield exactly (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) windows; no window SHALL straddle a row wrap or frame wrap.
REQ-025 frame_done SHALL pulse high for exactly one cycle, the first cycle out_valid is high for the window from pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-026 A new frame SHALL begin at row=0,col=0 with no flush; stale line-buffer content SHALL never appear in a valid window.

Reset
REQ-027 On rst_n low, asynchronously: out_valid=0, frame_done=0, row=0, col=0; out_window and line buffers need not be cleared.
REQ-028 After reset release, in_ready SHALL be 1 and the next accepted pixel SHALL be treated as (0,0); reset mid-frame SHALL discard the partial frame.

Verification
REQ-029 Ramp frame, pixel(r,c)=r*28+c raw, out_ready=1 -> first out_valid one cycle after accepting pixel (4,4); element 0=0, element 12=58, element 24=116.
REQ-030 Full ramp frame streaming continuously -> exactly 576 windows, one frame_done coincident with last window (element 24=783), no out_valid after col 0..3 accepts of any row.
REQ-031 out_ready held low 3 cycles while out_valid -> in_ready low, out_window unchanged, no pixel lost; windows resume with correct contents.
REQ-032 Reset asserted after 200 accepted pixels, then new ramp frame -> first window again after pixel (4,4) with element 0=0; no window from the aborted frame.
REQ-033 Two back-to-back frames with distinct constant values (0x0100 then 0x0200) -> every window of frame 2 contains only 0x0200.
REQ-034 Random in_valid/out_ready gaps over a ramp frame -> window sequence identical to REQ-030 reference.
